// File: rtl/npc_lsu.sv
// Load/store unit for the npc core: alignment check, byte-lane steering and load extension,
// one transaction at a time over a valid/ready memory port with an optional timeout.
module npc_lsu #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic [1:0]        resp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wmask,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StMem, StResp} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [XLEN-1:0]     wdata_q;
  logic [NB-1:0]       wmask_q;
  logic                we_q;
  logic [OFFW-1:0]     off_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]     rdata_q, rdata_d;
  logic [1:0]          err_q, err_d;
  logic                launch;

  // Request decode
  logic [OFFW-1:0]     off;
  logic [2:0]          align_mask;
  logic [7:0]          be_raw;
  logic                misaligned;
  logic                illegal;
  logic [NB-1:0]       wmask_new;
  logic [XLEN-1:0]     wdata_new;
  logic [ADDR_W-1:0]   addr_new;

  assign off = req_addr[OFFW-1:0];

  always_comb begin
    align_mask = 3'b111;
    be_raw     = 8'hFF;
    unique case (req_size)
      2'd0: begin align_mask = 3'b000; be_raw = 8'h01; end
      2'd1: begin align_mask = 3'b001; be_raw = 8'h03; end
      2'd2: begin align_mask = 3'b011; be_raw = 8'h0F; end
      default: begin align_mask = 3'b111; be_raw = 8'hFF; end
    endcase
  end

  assign misaligned = |(off & align_mask[OFFW-1:0]);
  assign illegal    = (XLEN == 32) && (req_size == 2'd3);
  assign wmask_new  = NB'(be_raw) << off;
  assign wdata_new  = req_wdata << {off, 3'b000};
  assign addr_new   = {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};

  // Load extraction: bring the addressed lane to bit 0, then sign/zero-extend
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] keep_mask;
  logic            sign_bit;
  logic [XLEN-1:0] ext_data;

  assign shifted = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    keep_mask = '1;
    sign_bit  = shifted[XLEN-1];
    unique case (size_q)
      2'd0: begin keep_mask = XLEN'(8'hFF);         sign_bit = shifted[7];  end
      2'd1: begin keep_mask = XLEN'(16'hFFFF);      sign_bit = shifted[15]; end
      2'd2: begin keep_mask = XLEN'(32'hFFFF_FFFF); sign_bit = shifted[31]; end
      default: begin keep_mask = '1; sign_bit = shifted[XLEN-1]; end
    endcase
    ext_data = (shifted & keep_mask) | ((sign_bit && !uns_q) ? ~keep_mask : '0);
  end

  logic timeout_hit;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    launch  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (misaligned || illegal) begin
            state_d = StResp;
            err_d   = 2'b01;
            rdata_d = '0;
          end else begin
            state_d = StMem;
            cnt_d   = '0;
            launch  = 1'b1;
          end
        end
      end
      StMem: begin
        cnt_d = cnt_q + CntW'(1);
        // mem_ready takes priority over a simultaneous timeout
        if (mem_ready) begin
          state_d = StResp;
          err_d   = 2'b00;
          rdata_d = we_q ? '0 : ext_data;
        end else if (timeout_hit) begin
          state_d = StResp;
          err_d   = 2'b10;
          rdata_d = '0;
        end
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      we_q    <= 1'b0;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (launch) begin
        addr_q  <= addr_new;
        wdata_q <= wdata_new;
        wmask_q <= wmask_new;
        we_q    <= req_we;
        off_q   <= off;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
      end
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign mem_valid  = (state_q == StMem);
  assign resp_valid = (state_q == StResp);
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wmask  = wmask_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
